// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch and load/store ports
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic [1:0]    grant
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, ACK} state_t;
    localparam logic [3:0] MW = 4'(MAX_WAIT);
    state_t     state;
    logic [3:0] starve_cnt;
    logic       force_if;
    assign force_if = if_req && (starve_cnt == MW);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            grant      <= 2'b00;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_req && !force_if) begin
                        state     <= BUSY_DM;
                        grant     <= 2'b10;
                        mem_en    <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        // cannot pass MAX_WAIT: a pending fetch at MAX_WAIT forces the fetch grant
                        starve_cnt <= starve_cnt + {3'b000, if_req};
                    end else if (if_req) begin
                        state      <= BUSY_IF;
                        grant      <= 2'b01;
                        mem_en     <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        starve_cnt <= 4'd0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    if (mem_rdy) begin
                        state  <= ACK;
                        grant  <= 2'b00;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (state == BUSY_IF) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end else begin
                            dm_ack <= 1'b1;
                            if (!mem_we) dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a transaction-level model
module tb_mem_port_arbiter;
    localparam int MW = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, dm_req, dm_we, mem_rdy;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, dm_ack, mem_en, mem_we;
    logic [1:0]  grant;
    logic [15:0] mem [0:255];
    int checks = 0;
    int failures = 0;
    int owner;
    bit in_ack;
    int losses;
    logic [15:0] lat_addr, lat_wdata, e_if_rdata, e_dm_rdata;
    logic lat_we, e_if_ack, e_dm_ack;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:0]];

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .grant(grant)
    );

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk16(name, {15'd0, act}, {15'd0, exp});
    endtask

    task automatic model_reset;
        owner = 0; in_ack = 0; losses = 0;
        lat_addr = '0; lat_wdata = '0; lat_we = 0;
        e_if_ack = 0; e_dm_ack = 0; e_if_rdata = '0; e_dm_rdata = '0;
    endtask

    // owner: 0 nobody, 1 fetch, 2 data; in_ack marks the completion cycle
    task automatic model_step;
        logic [7:0] a;
        e_if_ack = 0;
        e_dm_ack = 0;
        a = lat_addr[7:0];
        if (in_ack) in_ack = 0;
        else if (owner == 0) begin
            if (dm_req && !(if_req && losses == MW)) begin
                owner = 2; lat_addr = dm_addr; lat_wdata = dm_wdata; lat_we = dm_we;
                if (if_req && losses < MW) losses++;
            end else if (if_req) begin
                owner = 1; lat_addr = if_addr; lat_we = 0; losses = 0;
            end
        end else if (mem_rdy) begin
            if (owner == 1) begin
                e_if_ack = 1; e_if_rdata = mem[a];
            end else begin
                e_dm_ack = 1;
                if (lat_we) mem[a] = lat_wdata;
                else e_dm_rdata = mem[a];
            end
            owner = 0; in_ack = 1;
        end
    endtask

    task automatic model_compare;
        chk1("if_ack", if_ack, e_if_ack);
        chk1("dm_ack", dm_ack, e_dm_ack);
        chk16("if_rdata", if_rdata, e_if_rdata);
        chk16("dm_rdata", dm_rdata, e_dm_rdata);
        chk1("mem_en", mem_en, owner != 0);
        chk1("mem_we", mem_we, owner == 2 && lat_we);
        chk16("grant", 16'(grant), owner == 1 ? 16'd1 : owner == 2 ? 16'd2 : 16'd0);
        if (owner != 0) chk16("mem_addr", mem_addr, lat_addr);
        if (owner == 2 && lat_we) chk16("mem_wdata", mem_wdata, lat_wdata);
    endtask

    task automatic model_loop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
            #1 model_compare();
        end
    endtask

    task automatic end_access;
        @(negedge clk);
        if_req = 0; dm_req = 0; dm_we = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] g;
        int acks;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'hA5C3;
        model_reset();
        if_req = 0; dm_req = 0; dm_we = 0; mem_rdy = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        fork model_loop(); join_none
        repeat (2) @(negedge clk);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk16("rst_grant", 16'(grant), 16'd0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        rst_n = 1;
        // single fetch, zero wait states
        @(negedge clk);
        if_req = 1; if_addr = 16'h0010; mem_rdy = 1;
        @(posedge clk); #1;
        chk1("t1_mem_en", mem_en, 1'b1);
        chk1("t1_mem_we", mem_we, 1'b0);
        chk16("t1_mem_addr", mem_addr, 16'h0010);
        chk16("t1_grant", 16'(grant), 16'd1);
        @(posedge clk); #1;
        chk1("t1_if_ack", if_ack, 1'b1);
        chk16("t1_if_rdata", if_rdata, 16'hB5D3);
        end_access();
        // store with two wait states
        dm_req = 1; dm_we = 1; dm_addr = 16'h0200; dm_wdata = 16'hBEEF; mem_rdy = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk1("t2_mem_en", mem_en, 1'b1);
            chk1("t2_mem_we", mem_we, 1'b1);
            chk16("t2_mem_addr", mem_addr, 16'h0200);
            chk16("t2_mem_wdata", mem_wdata, 16'hBEEF);
            @(negedge clk);
            dm_wdata = 16'h1111;
            if (k == 2) mem_rdy = 1;
        end
        @(posedge clk); #1;
        chk1("t2_dm_ack", dm_ack, 1'b1);
        chk16("t2_dm_rdata", dm_rdata, 16'h0000);
        chk1("t2_mem_en_off", mem_en, 1'b0);
        end_access();
        // load whose address changes mid-access; reads back the stored word
        dm_req = 1; dm_addr = 16'h0300; mem_rdy = 0;
        @(posedge clk); #1;
        chk16("t4_addr0", mem_addr, 16'h0300);
        @(negedge clk);
        dm_addr = 16'h0304;
        @(posedge clk); #1;
        chk16("t4_addr1", mem_addr, 16'h0300);
        @(negedge clk);
        mem_rdy = 1;
        @(posedge clk); #1;
        chk1("t4_dm_ack", dm_ack, 1'b1);
        chk16("t4_dm_rdata", dm_rdata, 16'hBEEF);
        end_access();
        // contention: both requests held, fetch forced every MAX_WAIT+1 grants
        if_req = 1; dm_req = 1; dm_we = 0; if_addr = 16'h0004; dm_addr = 16'h0008; mem_rdy = 1;
        for (int n = 0; n < 10; n++) begin
            g = 2'b00;
            for (int t = 0; t < 10 && g == 2'b00; t++) begin
                @(posedge clk); #1;
                g = grant;
            end
            chk16("t3_grant", 16'(g), (n % (MW + 1) == MW) ? 16'd1 : 16'd2);
            if (n % (MW + 1) == MW) chk16("t3_starve", 16'(dut.starve_cnt), 16'd0);
        end
        @(posedge clk);
        end_access();
        // reset during a fetch, then back-to-back fetches
        if_req = 1; if_addr = 16'h0020; mem_rdy = 0;
        @(posedge clk); #1;
        chk1("t5_mem_en", mem_en, 1'b1);
        #2 rst_n = 0;
        #1;
        chk1("t5_rst_mem_en", mem_en, 1'b0);
        chk16("t5_rst_grant", 16'(grant), 16'd0);
        @(posedge clk); #1;
        chk1("t5_no_ack", if_ack, 1'b0);
        @(negedge clk);
        rst_n = 1; mem_rdy = 1;
        @(posedge clk); #1;
        chk16("t5_grant", 16'(grant), 16'd1);
        chk16("t5_mem_addr", mem_addr, 16'h0020);
        @(posedge clk); #1;
        chk1("t5_if_ack", if_ack, 1'b1);
        chk16("t5_if_rdata", if_rdata, 16'h85E3);
        @(posedge clk); #1;
        chk1("t6_idle_en", mem_en, 1'b0);
        @(posedge clk); #1;
        chk16("t6_regrant", 16'(grant), 16'd1);
        acks = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            acks += int'(if_ack);
        end
        chk16("t6_acks", 16'(acks), 16'd3);
        end_access();
        // randomized traffic with wait states and occasional resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (i % 500 == 499) begin
                rst_n = 0; if_req = 0; dm_req = 0;
                @(negedge clk);
                rst_n = 1;
                continue;
            end
            mem_rdy = ($urandom_range(0, 3) != 0);
            if (!if_req || if_ack) begin
                if_req = if_ack ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                if_addr = 16'($urandom_range(0, 15));
            end else if ($urandom_range(0, 3) == 0) if_addr = 16'($urandom_range(0, 15));
            if (!dm_req || dm_ack) begin
                dm_req = dm_ack ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                dm_addr = 16'($urandom_range(0, 15));
                dm_we = ($urandom_range(0, 1) == 1);
                dm_wdata = 16'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                dm_addr = 16'($urandom_range(0, 15));
                dm_wdata = 16'($urandom);
                dm_we = ($urandom_range(0, 1) == 1);
            end
        end
        end_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
